bshift_serial: RTL and testbench

- Multi-cycle shift unit for the RV32E core: the area-minimal, sequential counterpart of the single-cycle combinational barrel shifter.
- Executes SLL/SRL/SRA by iterating one bit position per clock under a start/busy/done handshake.
- Selected for small-footprint core builds; the ALU stalls the pipeline on `busy`.
- Operand and control encoding match the combinational shifter, so the two units are drop-in interchangeable at the ALU.

---
 rtl/bshift_serial_pkg.sv | 20 ++
 rtl/bshift_serial_step.sv | 23 ++
 rtl/bshift_serial.sv | 98 +++++++++
 tb/tb_bshift_serial.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_serial_pkg.sv
// Shared constants for the serial shifter: widths, FSM state encoding, fill-bit rule.
// Both builds (1-bit steps, or 4-bit steps with BSHIFT_SERIAL_STEP4_EN) use this package.
package bshift_serial_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int BIG_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Mode bits match the combinational shifter: lshift=1 -> SLL, else logical=1 -> SRL, else SRA.
  function automatic logic fill_bit(input logic msb, input logic logical);
    return msb & ~logical;
  endfunction

endpackage

// File: rtl/bshift_serial_step.sv
// One iteration of the serial shifter: next data value for a 1- or 4-position step
// in either direction, with the right-shift fill bit replicated into vacated positions.
module bshift_serial_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_lshift,
  input  logic             i_fill,
  input  logic             i_step4,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_sh1;
  logic [WIDTH-1:0] w_sh4;

  assign w_sh1 = i_lshift ? {i_data[WIDTH-2:0], 1'b0}
                          : {i_fill, i_data[WIDTH-1:1]};
  assign w_sh4 = i_lshift ? {i_data[WIDTH-5:0], 4'b0000}
                          : {{4{i_fill}}, i_data[WIDTH-1:4]};

  assign o_data = i_step4 ? w_sh4 : w_sh1;

endmodule

// File: rtl/bshift_serial.sv
// Multi-cycle SLL/SRL/SRA unit with start/busy/done handshake; one bit per clock, or
// four bits per clock while at least four remain when BSHIFT_SERIAL_STEP4_EN is defined.
module bshift_serial
  import bshift_serial_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             lshift,
  input  logic             logical,
  input  logic [SHW-1:0]   shift,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [SHW-1:0]   r_count;
  logic [SHW-1:0]   w_dec;
  logic             r_lshift;
  logic             r_fill;
  logic             w_accept;
  logic             w_step4;

`ifdef BSHIFT_SERIAL_STEP4_EN
  assign w_step4 = (r_count >= SHW'(BIG_STEP));
`else
  assign w_step4 = 1'b0;
`endif

  assign w_dec = w_step4 ? SHW'(BIG_STEP) : SHW'(1);

  bshift_serial_step #(.WIDTH(WIDTH)) u_step (
    .i_data   (r_data),
    .i_lshift (r_lshift),
    .i_fill   (r_fill),
    .i_step4  (w_step4),
    .o_data   (w_data_next)
  );

  // DONE accepts a new start like IDLE so operations can run back-to-back.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        busy = (r_state == ST_DONE);
        done = (r_state == ST_DONE);
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (shift == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_count == w_dec) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_count  <= '0;
      r_lshift <= 1'b0;
      r_fill   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data   <= in;
        r_count  <= shift;
        r_lshift <= lshift;
        r_fill   <= fill_bit(in[WIDTH-1], logical);
      end else if (r_state == ST_SHIFT) begin
        r_data  <= w_data_next;
        r_count <= r_count - w_dec;
      end
    end
  end

  assign out = r_data;

endmodule

// File: tb/tb_bshift_serial.sv
// Self-checking bench for bshift_serial: directed table, handshake corner cases,
// and a sweep of all amounts x modes against a plain-arithmetic shift model.
module tb_bshift_serial;

  logic        clock;
  logic        reset;
  logic        start;
  logic        lshift;
  logic        logical;
  logic [4:0]  shift;
  logic [31:0] tb_in;
  logic [31:0] tb_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  bshift_serial dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .lshift  (lshift),
    .logical (logical),
    .shift   (shift),
    .in      (tb_in),
    .out     (tb_out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        lsh;
    logic        lg;
    logic [4:0]  sh;
    logic [31:0] din;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic lsh, input logic lg, input int sh,
                                            input logic [31:0] d);
    if (lsh) return d << sh;
    else if (lg) return d >> sh;
    else return 32'($signed(d) >>> sh);
  endfunction

  function automatic int ref_lat(input int sh);
`ifdef BSHIFT_SERIAL_STEP4_EN
    return sh / 4 + sh % 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  // Counts cycles after the accept edge until done; busy must stay high throughout.
  task automatic wait_done(output int lat, output logic bok);
    lat = 0;
    bok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (!busy) bok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  // Issues one request, then scrambles the operands to show they are not re-sampled.
  task automatic run_op(input logic lsh, input logic lg, input logic [4:0] sh,
                        input logic [31:0] din, output logic [31:0] res,
                        output int lat, output logic bok);
    @(negedge clock);
    start = 1'b1; lshift = lsh; logical = lg; shift = sh; tb_in = din;
    @(posedge clock);
    #1;
    start = 1'b0;
    lshift = 1'($urandom); logical = 1'($urandom); shift = 5'($urandom); tb_in = $urandom;
    wait_done(lat, bok);
    res = tb_out;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] din;
    logic [31:0] exp;
    logic        bok;
    int          lat;
    int          elat;
    int          pulses;

    tbl[0] = '{1'b0, 1'b0, 5'd4,  32'h80000000, 32'hF8000000, 5,  2};
    tbl[1] = '{1'b1, 1'b0, 5'd31, 32'h00000001, 32'h80000000, 32, 11};
    tbl[2] = '{1'b0, 1'b1, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1,  1};
    tbl[3] = '{1'b0, 1'b1, 5'd8,  32'hF0000000, 32'h00F00000, 9,  3};
    tbl[4] = '{1'b1, 1'b1, 5'd4,  32'h12345678, 32'h23456780, 5,  2};
    tbl[5] = '{1'b0, 1'b0, 5'd31, 32'h7FFFFFFF, 32'h00000000, 32, 11};
    tbl[6] = '{1'b0, 1'b0, 5'd1,  32'h80000001, 32'hC0000000, 2,  2};
    tbl[7] = '{1'b0, 1'b1, 5'd31, 32'h80000000, 32'h00000001, 32, 11};

    reset = 1'b1; start = 1'b0; lshift = 1'b0; logical = 1'b0; shift = '0; tb_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out", tb_out, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
`ifdef BSHIFT_SERIAL_STEP4_EN
      elat = tbl[i].lat4;
`else
      elat = tbl[i].lat1;
`endif
      run_op(tbl[i].lsh, tbl[i].lg, tbl[i].sh, tbl[i].din, res, lat, bok);
      $display("vec %0d: lsh=%0d log=%0d sh=%0d in=%h out=%h lat=%0d", i, tbl[i].lsh,
               tbl[i].lg, tbl[i].sh, tbl[i].din, res, lat);
      check($sformatf("vec%0d_out", i), res, tbl[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(elat));
      check($sformatf("vec%0d_busy", i), 32'(bok), 32'h1);
      @(negedge clock);
      check($sformatf("vec%0d_idle", i), {30'h0, busy, done}, 32'h0);
    end

    // Start during SHIFT is ignored; start during DONE is accepted back-to-back.
    @(negedge clock);
    start = 1'b1; lshift = 1'b1; logical = 1'b0; shift = 5'd3; tb_in = 32'h1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 0; bok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (!busy) bok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      start = (c == 2);
      if (c == 2) begin
        tb_in = 32'hFFFFFFFF; shift = 5'd5; lshift = 1'b0;
      end
    end
    $display("busy-start: out=%h lat=%0d", tb_out, lat);
    check("ign_out", tb_out, 32'h00000008);
    check("ign_lat", 32'(lat), 32'd4);
    check("ign_busy", 32'(bok), 32'h1);
    start = 1'b1; lshift = 1'b0; logical = 1'b1; shift = 5'd2; tb_in = 32'h100;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    $display("b2b: out=%h lat=%0d", tb_out, lat);
    check("b2b_out", tb_out, 32'h00000040);
    check("b2b_lat", 32'(lat), 32'd3);
    check("b2b_busy", 32'(bok), 32'h1);

    // Reset in cycle 5 of a 20-position SRA aborts it with no done pulse.
    @(negedge clock);
    start = 1'b1; lshift = 1'b0; logical = 1'b0; shift = 5'd20; tb_in = 32'h80000000;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    $display("reset-mid-op: out=%h busy=%0d done=%0d", tb_out, busy, done);
    check("rst_mid_out", tb_out, 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    pulses = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check("rst_mid_no_done", 32'(pulses), 32'h0);

    // Reset wins over a simultaneous start.
    @(negedge clock);
    reset = 1'b1; start = 1'b1; shift = 5'd3; tb_in = 32'h5;
    @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    $display("reset+start: busy=%0d out=%h", busy, tb_out);
    check("rst_start_busy", 32'(busy), 32'h0);
    check("rst_start_out", tb_out, 32'h0);

    // Every amount in every mode with random data.
    for (int i = 0; i < 96; i++) begin
      logic lsh;
      logic lg;
      int   sh;
      sh  = i % 32;
      lsh = (i / 32) == 2;
      lg  = (i / 32) == 1;
      din = $urandom;
      exp = ref_shift(lsh, lg, sh, din);
      run_op(lsh, lg, 5'(sh), din, res, lat, bok);
      $display("rnd %0d: lsh=%0d log=%0d sh=%0d in=%h out=%h lat=%0d", i, lsh, lg, sh,
               din, res, lat);
      check($sformatf("rnd%0d_out", i), res, exp);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(sh)));
      check($sformatf("rnd%0d_busy", i), 32'(bok), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
